// File: rtl/hgradmag.sv
// Gradient magnitude / edge decision stage behind the x and y 3x3 convolvers.
// Forms a saturating L1 magnitude, optionally thresholds it, and tags each pixel with its frame position.
module hgradmag #(
    parameter logic [15:0] HIM_LEN  = 16'd520,
    parameter logic [15:0] HIM_ROWS = 16'd520,
    parameter logic [15:0] WARMUP   = HIM_LEN + 16'd2
) (
    input  logic        clk,
    input  logic        hres,
    input  logic        hstart,
    input  logic [7:0]  hgx,
    input  logic [7:0]  hgy,
    input  logic [7:0]  hthresh,
    input  logic        hmode,
    output logic [7:0]  hout,
    output logic        hvalid,
    output logic [15:0] hrow,
    output logic [15:0] hcol,
    output logic        hframe_done,
    output logic        hbusy
);

    typedef enum logic [1:0] {IDLE, WARM, RUN, DRAIN} state_t;

    state_t      state_reg, state_next;
    logic [15:0] warm_cnt_reg, warm_cnt_next;
    logic [15:0] row_reg, row_next;
    logic [15:0] col_reg, col_next;
    logic [1:0]  drain_cnt_reg, drain_cnt_next;
    logic        take_pixel;
    logic        pixel_last;
    logic        pixel_border;

    // Sample capture: raw inputs plus the position tag decided by the FSM
    logic        in_valid_reg;
    logic [7:0]  in_gx_reg, in_gy_reg, in_thresh_reg;
    logic        in_mode_reg;
    logic [15:0] in_row_reg, in_col_reg;
    logic        in_last_reg, in_border_reg;

    // Stage 1: unsaturated sum
    logic        s1_valid_reg;
    logic [8:0]  s1_sum_reg;
    logic [7:0]  s1_thresh_reg;
    logic        s1_mode_reg;
    logic [15:0] s1_row_reg, s1_col_reg;
    logic        s1_last_reg, s1_border_reg;

    logic [7:0]  mag_sat;
    logic [7:0]  pixel_value;

    assign pixel_last   = (row_reg == HIM_ROWS - 16'd1) && (col_reg == HIM_LEN - 16'd1);
    assign pixel_border = (row_reg == 16'd0) || (row_reg == HIM_ROWS - 16'd1) ||
                          (col_reg == 16'd0) || (col_reg == HIM_LEN - 16'd1);
    assign hbusy        = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (hres) begin
            state_reg     <= IDLE;
            warm_cnt_reg  <= 16'd0;
            row_reg       <= 16'd0;
            col_reg       <= 16'd0;
            drain_cnt_reg <= 2'd0;
        end else begin
            state_reg     <= state_next;
            warm_cnt_reg  <= warm_cnt_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        warm_cnt_next  = warm_cnt_reg;
        row_next       = row_reg;
        col_next       = col_reg;
        drain_cnt_next = drain_cnt_reg;
        take_pixel     = 1'b0;
        if (hstart) begin
            // A start pulse in any state (re)begins a frame from warm-up
            state_next     = WARM;
            warm_cnt_next  = 16'd0;
            row_next       = 16'd0;
            col_next       = 16'd0;
            drain_cnt_next = 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                end
                WARM: begin
                    if (warm_cnt_reg == WARMUP - 16'd1) begin
                        state_next    = RUN;
                        warm_cnt_next = 16'd0;
                    end else begin
                        warm_cnt_next = warm_cnt_reg + 16'd1;
                    end
                end
                RUN: begin
                    take_pixel = 1'b1;
                    if (col_reg == HIM_LEN - 16'd1) begin
                        col_next = 16'd0;
                        if (row_reg == HIM_ROWS - 16'd1) begin
                            row_next   = 16'd0;
                            state_next = DRAIN;
                        end else begin
                            row_next = row_reg + 16'd1;
                        end
                    end else begin
                        col_next = col_reg + 16'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == 2'd2) begin
                        state_next     = IDLE;
                        drain_cnt_next = 2'd0;
                    end else begin
                        drain_cnt_next = drain_cnt_reg + 2'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (hres) begin
            in_valid_reg  <= 1'b0;
            in_gx_reg     <= 8'd0;
            in_gy_reg     <= 8'd0;
            in_thresh_reg <= 8'd0;
            in_mode_reg   <= 1'b0;
            in_row_reg    <= 16'd0;
            in_col_reg    <= 16'd0;
            in_last_reg   <= 1'b0;
            in_border_reg <= 1'b0;
        end else begin
            in_valid_reg  <= take_pixel;
            in_gx_reg     <= hgx;
            in_gy_reg     <= hgy;
            in_thresh_reg <= hthresh;
            in_mode_reg   <= hmode;
            in_row_reg    <= row_reg;
            in_col_reg    <= col_reg;
            in_last_reg   <= pixel_last;
            in_border_reg <= pixel_border;
        end
    end

    // Valid bits are killed by a start pulse so an abandoned frame never reaches the output
    always_ff @(posedge clk) begin
        if (hres) begin
            s1_valid_reg  <= 1'b0;
            s1_sum_reg    <= 9'd0;
            s1_thresh_reg <= 8'd0;
            s1_mode_reg   <= 1'b0;
            s1_row_reg    <= 16'd0;
            s1_col_reg    <= 16'd0;
            s1_last_reg   <= 1'b0;
            s1_border_reg <= 1'b0;
        end else begin
            s1_valid_reg  <= in_valid_reg && !hstart;
            s1_sum_reg    <= {1'b0, in_gx_reg} + {1'b0, in_gy_reg};
            s1_thresh_reg <= in_thresh_reg;
            s1_mode_reg   <= in_mode_reg;
            s1_row_reg    <= in_row_reg;
            s1_col_reg    <= in_col_reg;
            s1_last_reg   <= in_last_reg;
            s1_border_reg <= in_border_reg;
        end
    end

    always_comb begin
        mag_sat     = s1_sum_reg[8] ? 8'hFF : s1_sum_reg[7:0];
        pixel_value = mag_sat;
        if (s1_mode_reg) begin
            pixel_value = (mag_sat >= s1_thresh_reg) ? 8'hFF : 8'h00;
        end
        if (s1_border_reg) begin
            pixel_value = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (hres) begin
            hvalid      <= 1'b0;
            hout        <= 8'd0;
            hrow        <= 16'd0;
            hcol        <= 16'd0;
            hframe_done <= 1'b0;
        end else if (s1_valid_reg && !hstart) begin
            hvalid      <= 1'b1;
            hout        <= pixel_value;
            hrow        <= s1_row_reg;
            hcol        <= s1_col_reg;
            hframe_done <= s1_last_reg;
        end else begin
            hvalid      <= 1'b0;
            hout        <= 8'd0;
            hrow        <= 16'd0;
            hcol        <= 16'd0;
            hframe_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hgradmag.sv
// Self-checking bench for hgradmag: a small frame (4x3, warm-up 2) driven cycle by cycle
// and compared against a position/arithmetic reference model.
module tb_hgradmag;
    localparam int LEN  = 4;
    localparam int ROWS = 3;
    localparam int WU   = 2;
    localparam int N    = LEN * ROWS;
    localparam int LAT  = WU + 3;   // pixel p is observed after edge E(p+LAT)

    logic        clk = 1'b0;
    logic        hres, hstart, hmode;
    logic [7:0]  hgx, hgy, hthresh;
    logic [7:0]  hout;
    logic        hvalid, hframe_done, hbusy;
    logic [15:0] hrow, hcol;

    int errors = 0;
    int checks = 0;
    int gx_log [0:127];
    int gy_log [0:127];
    int th_log [0:127];
    bit md_log [0:127];

    hgradmag #(.HIM_LEN(16'd4), .HIM_ROWS(16'd3), .WARMUP(16'd2)) dut (
        .clk(clk), .hres(hres), .hstart(hstart), .hgx(hgx), .hgy(hgy),
        .hthresh(hthresh), .hmode(hmode), .hout(hout), .hvalid(hvalid),
        .hrow(hrow), .hcol(hcol), .hframe_done(hframe_done), .hbusy(hbusy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_pixel(input int p, input int gx, input int gy,
                                             input int th, input bit md);
        int row;
        int col;
        int mag;
        row = p / LEN;
        col = p % LEN;
        if (row == 0 || row == ROWS - 1 || col == 0 || col == LEN - 1) return 8'd0;
        mag = gx + gy;
        if (mag > 255) mag = 255;
        if (md) return (mag >= th) ? 8'd255 : 8'd0;
        return 8'(mag);
    endfunction

    // Drive one cycle of inputs, then advance past the next rising edge
    task automatic step(input logic [7:0] gx, input logic [7:0] gy, input logic [7:0] th,
                        input logic md, input logic st, input logic rs);
        hgx = gx; hgy = gy; hthresh = th; hmode = md; hstart = st; hres = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++)
            step(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        checks++; if (hout !== 8'd0) begin errors++; $display("FAIL reset_hout: got %0d want 0", hout); end
        checks++; if (hvalid !== 1'b0) begin errors++; $display("FAIL reset_hvalid: got %b want 0", hvalid); end
        checks++; if (hframe_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", hframe_done); end
        checks++; if (hbusy !== 1'b0) begin errors++; $display("FAIL reset_hbusy: got %b want 0", hbusy); end
        checks++; if (hrow !== 16'd0) begin errors++; $display("FAIL reset_hrow: got %0d want 0", hrow); end
        checks++; if (hcol !== 16'd0) begin errors++; $display("FAIL reset_hcol: got %0d want 0", hcol); end
        $display("reset: outputs after 2 reset cycles hout=%0d hvalid=%b hbusy=%b", hout, hvalid, hbusy);
    endtask

    task automatic test_full_frame();
        int p;
        logic exp_v;
        for (int c = 0; c <= N + LAT + 3; c++) begin
            step(8'd10, 8'd20, 8'd0, 1'b0, c == 0, 1'b0);
            p = c - LAT;
            exp_v = (p >= 0 && p < N);
            checks++;
            if (hvalid !== exp_v) begin errors++; $display("FAIL full_valid c=%0d: got %b want %b", c, hvalid, exp_v); end
            checks++;
            if (hbusy !== (c <= N + LAT - 1)) begin errors++; $display("FAIL full_busy c=%0d: got %b want %b", c, hbusy, c <= N + LAT - 1); end
            if (exp_v) begin
                checks++;
                if (hrow !== 16'(p / LEN) || hcol !== 16'(p % LEN)) begin
                    errors++; $display("FAIL full_pos p=%0d: got (%0d,%0d) want (%0d,%0d)", p, hrow, hcol, p / LEN, p % LEN);
                end
                checks++;
                if (hout !== ref_pixel(p, 10, 20, 0, 1'b0)) begin
                    errors++; $display("FAIL full_hout p=%0d: got %0d want %0d", p, hout, ref_pixel(p, 10, 20, 0, 1'b0));
                end
                checks++;
                if (hframe_done !== (p == N - 1)) begin errors++; $display("FAIL full_done p=%0d: got %b want %b", p, hframe_done, p == N - 1); end
                $display("full: p=%0d (%0d,%0d) hout=%0d done=%b", p, hrow, hcol, hout, hframe_done);
            end else begin
                checks++;
                if (hframe_done !== 1'b0) begin errors++; $display("FAIL full_done_idle c=%0d: got %b want 0", c, hframe_done); end
            end
        end
    endtask

    task automatic test_saturation_threshold();
        int gxs  [4] = '{200, 10, 10, 255};
        int gys  [4] = '{100, 20, 20, 255};
        int ths  [4] = '{0, 30, 31, 0};
        bit mds  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int want [4] = '{255, 255, 0, 255};
        int p;
        int exp_o;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c <= N + LAT + 3; c++) begin
                step(8'(gxs[k]), 8'(gys[k]), 8'(ths[k]), mds[k], c == 0, 1'b0);
                p = c - LAT;
                if (p >= 0 && p < N) begin
                    exp_o = (p / LEN == 0 || p / LEN == ROWS - 1 || p % LEN == 0 || p % LEN == LEN - 1) ? 0 : want[k];
                    checks++;
                    if (hout !== 8'(exp_o)) begin
                        errors++; $display("FAIL satthr_hout cfg=%0d p=%0d: got %0d want %0d", k, p, hout, exp_o);
                    end
                end
            end
            $display("satthr: cfg=%0d gx=%0d gy=%0d th=%0d mode=%0d interior want %0d", k, gxs[k], gys[k], ths[k], mds[k], want[k]);
        end
    endtask

    task automatic test_random_frames();
        int p;
        int s;
        logic exp_v;
        logic [7:0] exp_o;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c <= N + LAT + 3; c++) begin
                gx_log[c] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(128, 255)) : int'($urandom_range(0, 127));
                gy_log[c] = int'($urandom_range(0, 255));
                th_log[c] = int'($urandom_range(0, 255));
                md_log[c] = 1'($urandom);
                step(8'(gx_log[c]), 8'(gy_log[c]), 8'(th_log[c]), md_log[c], c == 0, 1'b0);
                p = c - LAT;
                exp_v = (p >= 0 && p < N);
                checks++;
                if (hvalid !== exp_v) begin errors++; $display("FAIL rand_valid f=%0d c=%0d: got %b want %b", f, c, hvalid, exp_v); end
                if (exp_v) begin
                    s = p + WU + 1;
                    exp_o = ref_pixel(p, gx_log[s], gy_log[s], th_log[s], md_log[s]);
                    checks++;
                    if (hout !== exp_o) begin
                        errors++; $display("FAIL rand_hout f=%0d p=%0d: got %0d want %0d", f, p, hout, exp_o);
                    end
                    $display("rand: f=%0d p=%0d gx=%0d gy=%0d th=%0d md=%0d hout=%0d", f, p, gx_log[s], gy_log[s], th_log[s], md_log[s], hout);
                end
            end
        end
    endtask

    task automatic test_restart();
        localparam int RS = WU + 1 + 5;   // restart in the cycle pixel 5 would be sampled
        int cp;
        int pn;
        int nvalid = 0;
        int ndone  = 0;
        bit first  = 1'b1;
        for (int c = 0; c <= RS + N + LAT + 3; c++) begin
            gx_log[c] = int'($urandom_range(0, 255));
            gy_log[c] = int'($urandom_range(0, 255));
            step(8'(gx_log[c]), 8'(gy_log[c]), 8'd0, 1'b0, (c == 0) || (c == RS), 1'b0);
            if (c >= RS) begin
                cp = c - RS;
                pn = cp - LAT;
                if (cp < 4) begin
                    checks++;
                    if (hvalid !== 1'b0) begin errors++; $display("FAIL restart_gap cp=%0d: got %b want 0", cp, hvalid); end
                end
                if (hvalid === 1'b1) nvalid++;
                if (hframe_done === 1'b1) ndone++;
                if (hvalid === 1'b1 && first) begin
                    first = 1'b0;
                    checks++;
                    if (hrow !== 16'd0 || hcol !== 16'd0) begin
                        errors++; $display("FAIL restart_first_pos: got (%0d,%0d) want (0,0)", hrow, hcol);
                    end
                end
                if (pn >= 0 && pn < N) begin
                    checks++;
                    if (hout !== ref_pixel(pn, gx_log[RS + pn + WU + 1], gy_log[RS + pn + WU + 1], 0, 1'b0)) begin
                        errors++; $display("FAIL restart_hout p=%0d: got %0d want %0d", pn, hout,
                                           ref_pixel(pn, gx_log[RS + pn + WU + 1], gy_log[RS + pn + WU + 1], 0, 1'b0));
                    end
                end
            end
        end
        checks++; if (nvalid != N) begin errors++; $display("FAIL restart_nvalid: got %0d want %0d", nvalid, N); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL restart_ndone: got %0d want 1", ndone); end
        $display("restart: valid=%0d done=%0d after restart", nvalid, ndone);
    endtask

    task automatic test_midframe_reset();
        localparam int RST = WU + 1 + 7;
        int nvalid = 0;
        int ndone  = 0;
        int nbusy  = 0;
        for (int c = 0; c <= RST + 20; c++) begin
            step(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), c == 0, c == RST);
            if (c == RST) begin
                checks++;
                if (hout !== 8'd0 || hvalid !== 1'b0 || hframe_done !== 1'b0 || hbusy !== 1'b0 ||
                    hrow !== 16'd0 || hcol !== 16'd0) begin
                    errors++;
                    $display("FAIL midreset_outputs: got hout=%0d hvalid=%b done=%b busy=%b row=%0d col=%0d want all 0",
                             hout, hvalid, hframe_done, hbusy, hrow, hcol);
                end
            end else if (c > RST) begin
                if (hvalid === 1'b1) nvalid++;
                if (hframe_done === 1'b1) ndone++;
                if (hbusy === 1'b1) nbusy++;
            end
        end
        checks++; if (nvalid != 0) begin errors++; $display("FAIL midreset_valid: got %0d want 0", nvalid); end
        checks++; if (ndone != 0) begin errors++; $display("FAIL midreset_done: got %0d want 0", ndone); end
        checks++; if (nbusy != 0) begin errors++; $display("FAIL midreset_busy: got %0d want 0", nbusy); end
        $display("midreset: after reset valid=%0d done=%0d busy=%0d", nvalid, ndone, nbusy);
    endtask

    task automatic test_back_to_back();
        int nvalid = 0;
        int ndone  = 0;
        bit restart_now = 1'b0;
        bit seen_second = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step(8'd50, 8'd60, 8'd0, 1'b0, (c == 0) || restart_now, 1'b0);
            restart_now = 1'b0;
            if (!seen_second) begin
                checks++;
                if (hbusy !== 1'b1) begin errors++; $display("FAIL b2b_busy c=%0d: got %b want 1", c, hbusy); end
            end
            if (hvalid === 1'b1) begin
                checks++;
                if (hrow !== 16'((nvalid % N) / LEN) || hcol !== 16'((nvalid % N) % LEN)) begin
                    errors++; $display("FAIL b2b_pos n=%0d: got (%0d,%0d) want (%0d,%0d)", nvalid, hrow, hcol,
                                       (nvalid % N) / LEN, (nvalid % N) % LEN);
                end
                nvalid++;
            end
            if (hframe_done === 1'b1) begin
                ndone++;
                if (ndone == 1) restart_now = 1'b1;
                if (ndone == 2) seen_second = 1'b1;
                $display("b2b: frame_done #%0d at c=%0d", ndone, c);
            end
        end
        checks++; if (nvalid != 2 * N) begin errors++; $display("FAIL b2b_nvalid: got %0d want %0d", nvalid, 2 * N); end
        checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_ndone: got %0d want 2", ndone); end
    endtask

    initial begin
        hres = 1'b1; hstart = 1'b0; hgx = 8'd0; hgy = 8'd0; hthresh = 8'd0; hmode = 1'b0;
        test_reset();
        test_full_frame();
        test_saturation_threshold();
        test_random_frames();
        test_restart();
        test_midframe_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
